lfsr_sched: RTL and testbench
=============================

LFSR_SCHED -- requirements
Module: lfsr_sched

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: port clk clocks all state, and port reset, sampled on the rising clk edge, is the reset.
REQ-002 The block SHALL have parameter STEPS, default 4: number of LFSR advances per draw, legal range 1..15.
REQ-003 The block SHALL have these ports:
- clk  input  1  clock.
- reset  input  1  synchronous active-high reset.
- req  input  4  per-requester draw request, level.
- gnt  output  4  one-hot grant pulse; rnd valid in the same cycle.
- rnd  output  8  delivered random byte.
- lfsr_enable  output  1  step enable to the shared 8-bit LFSR.
- lfsr_reset  output  1  reset to the shared LFSR.
- lfsr_value  input  8  current LFSR state.
- stuck  output  1  sticky flag: LFSR lock-up was detected.

Function
REQ-004 The block SHALL share one LFSR among 4 requesters, granting one fresh byte per draw after exactly STEPS advances.
REQ-005 The FSM SHALL have states IDLE, STEP, DELIVER and RECOVER.
REQ-006 IDLE SHALL behave as follows:
- If any req bit is high, pick the winner round-robin: start at ptr, search upward with wrap 3->0.
- Latch the winner, load step counter = STEPS, go to STEP.
- Register lfsr_enable = 1.
REQ-007 STEP SHALL behave as follows:
- lfsr_enable is high for exactly STEPS consecutive cycles.
- The counter decrements each cycle.
- On the last step, drop lfsr_enable and go to DELIVER.
REQ-008 DELIVER SHALL behave as follows:
- If req[winner] is still high, register rnd = lfsr_value and gnt = one-hot(winner), set ptr = winner+1 mod 4.
- Otherwise cancel the grant: gnt stays 0, rnd and ptr are unchanged.
- Always return to IDLE.
REQ-009 Latency SHALL be STEPS+2 cycles:
- Request sampled in IDLE at cycle T.
- lfsr_enable high in cycles T+1..T+STEPS.
- gnt visible in cycle T+STEPS+2.
REQ-010 gnt SHALL be high for exactly one cycle per draw, with at most one bit set.
REQ-011 rnd SHALL hold its value until the next grant.
REQ-012 A req bit high during its own gnt cycle SHALL count as a new request; back-to-back draws are allowed.
REQ-013 Requesters SHALL hold req until gnt; dropping it earlier forfeits the draw and the consumed LFSR steps.
REQ-014 lfsr_enable and lfsr_reset SHALL never be high in the same cycle.

Reset
REQ-015 While reset is high, the block SHALL force:
- state = IDLE, ptr = 0, counter = 0.
- gnt = 0, rnd = 8'h00, lfsr_enable = 0, stuck = 0.
- lfsr_reset = 1.
REQ-016 lfsr_reset SHALL remain high for the first cycle after reset deasserts, then go to 0.
REQ-017 No arbitration SHALL occur in any cycle where lfsr_reset is high.
REQ-018 Reset SHALL abort any draw in progress with no grant issued.

Configuration
REQ-019 The stuck-detection feature SHALL be compiled in or out by macro LFSR_SCHED_STUCK_EN.
REQ-020 With LFSR_SCHED_STUCK_EN defined, the block SHALL detect and recover from lock-up:
- Detection: in any STEP or DELIVER cycle whose preceding cycle had lfsr_enable = 1, lfsr_value equal to its previous-cycle value is a lock-up.
- On lock-up, go to RECOVER: drive lfsr_reset high for exactly 2 cycles and set stuck = 1, sticky until reset.
- After RECOVER, reload counter = STEPS and re-enter STEP for the same winner; a full STEPS sequence follows.
REQ-021 Without LFSR_SCHED_STUCK_EN, the block SHALL:
- Have no RECOVER state.
- Tie stuck to 0.
- Assert lfsr_reset only per REQ-015 and REQ-016.

Verification
REQ-022 The bench SHALL cover these directed scenarios (STEPS=4, real LFSR unless noted):
- Single request: reset, then req = 4'b0001 at T -> lfsr_enable high T+1..T+4; gnt = 4'b0001 at T+6 for one cycle; rnd equals lfsr_value after 4 advances.
- Round-robin fairness: req = 4'b1111 held for 4 draws -> grant order 0001, 0010, 0100, 1000; the fifth draw grants 0001.
- Cancellation: req = 4'b0100 dropped at T+3 -> no gnt; rnd unchanged; the next req = 4'b0100 is granted normally with ptr unchanged.
- Mid-draw reset: reset pulsed at T+2 of a draw -> gnt stays 0; lfsr_enable = 0 the cycle after reset is sampled; lfsr_reset high through the first post-reset cycle; rnd = 8'h00.
- Stuck detection (macro on): bench model holds lfsr_value = 8'h00 -> lfsr_reset high for 2 cycles, stuck = 1, a full 4-step STEP retry follows. With macro off, the same stimulus gives gnt with rnd = 8'h00 and stuck = 0.

Source files
------------

// File: rtl/lfsr_sched.sv
// rtl/lfsr_sched.sv - Round-robin scheduler sharing one 8-bit LFSR among 4 requesters.
// Optional LFSR lock-up detection and recovery: define LFSR_SCHED_STUCK_EN.
module lfsr_sched #(
    parameter int STEPS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [7:0] rnd,
    output logic       lfsr_enable,
    output logic       lfsr_reset,
    input  logic [7:0] lfsr_value,
    output logic       stuck
);

`ifdef LFSR_SCHED_STUCK_EN
    typedef enum logic [1:0] {IDLE, STEP, DELIVER, RECOVER} state_t;
`else
    typedef enum logic [1:0] {IDLE, STEP, DELIVER} state_t;
`endif

    localparam logic [3:0] STEP_LOAD = 4'(STEPS);

    state_t     state;
    logic [1:0] ptr;
    logic [1:0] winner;
    logic [1:0] pick;
    logic       pick_valid;
    logic [3:0] cnt;

    // Scan from the farthest offset down so the requester nearest ptr wins.
    always_comb begin
        pick       = ptr;
        pick_valid = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (req[ptr + 2'(i)]) begin
                pick       = ptr + 2'(i);
                pick_valid = 1'b1;
            end
        end
    end

`ifdef LFSR_SCHED_STUCK_EN
    logic       en_d;
    logic [7:0] prev_value;
    logic       rec_second;
    logic       lockup;

    // A stepped LFSR that repeats its value has fallen into its fixed point.
    assign lockup = (state == STEP || state == DELIVER) && en_d && (lfsr_value == prev_value);

    always_ff @(posedge clk) begin
        if (reset) begin
            en_d       <= 1'b0;
            prev_value <= 8'h00;
        end else begin
            en_d       <= lfsr_enable;
            prev_value <= lfsr_value;
        end
    end
`else
    assign stuck = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= 2'd0;
            winner      <= 2'd0;
            cnt         <= 4'd0;
            gnt         <= 4'd0;
            rnd         <= 8'h00;
            lfsr_enable <= 1'b0;
            lfsr_reset  <= 1'b1;
`ifdef LFSR_SCHED_STUCK_EN
            stuck       <= 1'b0;
            rec_second  <= 1'b0;
`endif
        end else begin
            gnt        <= 4'd0;
            lfsr_reset <= 1'b0;
            case (state)
                IDLE: begin
                    if (!lfsr_reset && pick_valid) begin
                        winner      <= pick;
                        cnt         <= STEP_LOAD;
                        lfsr_enable <= 1'b1;
                        state       <= STEP;
                    end
                end
                STEP: begin
`ifdef LFSR_SCHED_STUCK_EN
                    if (lockup) begin
                        lfsr_enable <= 1'b0;
                        lfsr_reset  <= 1'b1;
                        stuck       <= 1'b1;
                        rec_second  <= 1'b0;
                        state       <= RECOVER;
                    end else
`endif
                    begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            lfsr_enable <= 1'b0;
                            state       <= DELIVER;
                        end
                    end
                end
                DELIVER: begin
                    state <= IDLE;
`ifdef LFSR_SCHED_STUCK_EN
                    if (lockup) begin
                        lfsr_reset <= 1'b1;
                        stuck      <= 1'b1;
                        rec_second <= 1'b0;
                        state      <= RECOVER;
                    end else
`endif
                    if (req[winner]) begin
                        gnt <= 4'b0001 << winner;
                        rnd <= lfsr_value;
                        ptr <= winner + 2'd1;
                    end
                end
`ifdef LFSR_SCHED_STUCK_EN
                RECOVER: begin
                    if (!rec_second) begin
                        rec_second <= 1'b1;
                        lfsr_reset <= 1'b1;
                    end else begin
                        lfsr_enable <= 1'b1;
                        cnt         <= STEP_LOAD;
                        state       <= STEP;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_sched.sv
// tb/tb_lfsr_sched.sv - Scoreboard bench for lfsr_sched with a behavioural 8-bit LFSR.
module tb_lfsr_sched;

    localparam logic [7:0] SEED = 8'h01;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = 4'd0;
    logic [3:0] gnt;
    logic [7:0] rnd;
    logic       lfsr_enable;
    logic       lfsr_reset;
    logic [7:0] lfsr_value;
    logic       stuck;

    logic [7:0] lv = 8'h00;
    logic       lock_req = 1'b0;
    logic       lock_done = 1'b0;
    logic [7:0] exp_lv;
    logic [11:0] sb[$];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lfsr_sched #(.STEPS(4)) dut (
        .clk(clk), .reset(reset), .req(req), .gnt(gnt), .rnd(rnd),
        .lfsr_enable(lfsr_enable), .lfsr_reset(lfsr_reset),
        .lfsr_value(lfsr_value), .stuck(stuck)
    );

    function automatic logic [7:0] adv(input logic [7:0] v, input int n);
        logic [7:0] x;
        x = v;
        for (int i = 0; i < n; i++) x = {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
        return x;
    endfunction

    // Shared LFSR; lock_req forces the lock-up value until the next lfsr_reset.
    assign lfsr_value = lv;
    always @(posedge clk) begin
        if (lfsr_reset === 1'b1) begin
            lv        <= SEED;
            lock_done <= lock_req;
        end else if (lock_req && !lock_done) begin
            lv <= 8'h00;
        end else if (lfsr_enable === 1'b1) begin
            lv <= adv(lv, 1);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (gnt !== 4'd0) begin
            chk("gnt_onehot", 32'($countones(gnt)), 32'd1);
            if (sb.size() == 0) begin
                chk("unexpected_gnt", {20'd0, gnt, rnd}, 32'd0);
            end else begin
                chk("grant", {20'd0, gnt, rnd}, {20'd0, sb.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 4'd0;
        tick();
        tick();
        reset  = 1'b0;
        exp_lv = SEED;
        chk("post_rst_lfsr_reset", 32'(lfsr_reset), 32'd1);
        chk("post_rst_outs", {14'd0, gnt, rnd, lfsr_enable, stuck}, 32'd0);
        tick();
        chk("lfsr_reset_release", 32'(lfsr_reset), 32'd0);
    endtask

    initial begin
        // Single request: seed 01 -> 02,04,08,11 after four advances.
        do_reset();
        req = 4'b0001;
        sb.push_back({4'b0001, 8'h11});
        exp_lv = adv(exp_lv, 4);
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("single_en_T%0d", k), 32'(lfsr_enable), (k <= 4) ? 32'd1 : 32'd0);
            chk("en_rst_exclusive", 32'(lfsr_enable & lfsr_reset), 32'd0);
        end
        tick();
        req = 4'd0;
        tick();
        chk("single_gnt_one_cycle", 32'(gnt), 32'd0);
        chk("rnd_hold", 32'(rnd), 32'h11);

        // Mid-draw reset
        req = 4'b0010;
        tick();
        tick();
        reset = 1'b1;
        req   = 4'd0;
        tick();
        reset = 1'b0;
        chk("mid_rst_en", 32'(lfsr_enable), 32'd0);
        chk("mid_rst_lfsr_reset", 32'(lfsr_reset), 32'd1);
        chk("mid_rst_rnd", 32'(rnd), 32'h00);
        tick();
        chk("mid_rst_lfsr_reset_low", 32'(lfsr_reset), 32'd0);
        repeat (8) tick();

        // Round-robin fairness, back-to-back draws
        do_reset();
        req = 4'b1111;
        for (int d = 0; d < 5; d++) begin
            exp_lv = adv(exp_lv, 4);
            sb.push_back({4'b0001 << (d % 4), exp_lv});
        end
        repeat (30) tick();
        req = 4'd0;
        repeat (3) tick();

        // Cancellation forfeits the steps; the retry gets the following bytes.
        do_reset();
        req = 4'b0100;
        exp_lv = adv(exp_lv, 4);
        repeat (3) tick();
        req = 4'd0;
        repeat (4) tick();
        chk("cancel_rnd", 32'(rnd), 32'h00);
        req = 4'b0100;
        exp_lv = adv(exp_lv, 4);
        sb.push_back({4'b0100, exp_lv});
        repeat (6) tick();
        req = 4'd0;
        repeat (2) tick();

        // LFSR lock-up
        do_reset();
        lock_req = 1'b1;
        tick();
        req = 4'b0001;
`ifdef LFSR_SCHED_STUCK_EN
        sb.push_back({4'b0001, 8'h11});
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk($sformatf("stuck_en_T%0d", k), 32'(lfsr_enable),
                (k <= 2 || (k >= 5 && k <= 8)) ? 32'd1 : 32'd0);
            chk($sformatf("stuck_lrst_T%0d", k), 32'(lfsr_reset),
                (k == 3 || k == 4) ? 32'd1 : 32'd0);
        end
        chk("stuck_flag", 32'(stuck), 32'd1);
        tick();
        req = 4'd0;
        repeat (2) tick();
        chk("stuck_sticky", 32'(stuck), 32'd1);
`else
        sb.push_back({4'b0001, 8'h00});
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("nostuck_en_T%0d", k), 32'(lfsr_enable), (k <= 4) ? 32'd1 : 32'd0);
            chk($sformatf("nostuck_lrst_T%0d", k), 32'(lfsr_reset), 32'd0);
        end
        tick();
        req = 4'd0;
        repeat (2) tick();
        chk("nostuck_flag", 32'(stuck), 32'd0);
`endif
        lock_req = 1'b0;
        repeat (3) tick();
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
